serial_adder: RTL and testbench

- Bit-serial adder: computes a + b + cin one bit per clock, LSB first, using a single 1-bit full-adder cell and a carry flip-flop.
- Inverse-operation companion to the 4-bit ripple-borrow subtracter. A diff produced by the subtracter can be added back to b to recover a for self-checking.
- Start/busy/done handshake; result held stable in output registers until the next accepted start.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder_bit.sv | 13 +
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the derived bit-counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Counter must be able to hold values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// One-bit combinational full-adder cell, shared by serial arithmetic blocks.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin computed LSB first through one full-adder
// cell, with a start/busy/done handshake and held result registers.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_capture;
  logic               w_last;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_s;
  logic               w_co;

  full_adder_bit u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_capture) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_acc   <= w_acc_nxt;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_co;
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
      end
    end else begin
      r_a_sh  <= r_a_sh;
      r_b_sh  <= r_b_sh;
      r_acc   <= r_acc;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4) with a result scoreboard.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;
  logic [WIDTH:0] exp_q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive start for one cycle (from a negedge) and record the expected result.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc,
                        input bit record);
    start = 1'b1; a = ta; b = tb_; cin = tc;
    if (record) exp_q.push_back({1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'b0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b sum=%b cout=%b want 0 0 0000 0", busy, done, sum, cout);
    end
    rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_op cycle %0d got busy=%b done=%b want 0 0", i, busy, done);
      end
    end
  endtask

  // Run one op from IDLE: busy for WIDTH cycles, done one cycle, then hold.
  task automatic test_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc);
    logic [WIDTH:0] exp;
    logic [WIDTH:0] prev;
    prev = {cout, sum};
    launch(ta, tb_, tc, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {cout, sum} !== prev) begin
        errors++;
        $display("FAIL %s_busy cycle %0d got busy=%b done=%b res=%b want 1 0 %b", name, i, busy, done, {cout, sum}, prev);
      end
      @(negedge clk);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b cout=%b sum=%b want 1 0 %b %b", name, done, busy, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL %s_hold cycle %0d got done=%b busy=%b res=%b want 0 0 %b", name, i, done, busy, {cout, sum}, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [WIDTH:0] exp;
    launch(4'd2, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd7; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL swb_busy got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checks++;
    if (done !== 1'b1 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL swb_done got done=%b res=%b want 1 %b", done, {cout, sum}, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL swb_after got busy=%b done=%b res=%b want 0 0 %b", busy, done, {cout, sum}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp;
    start = 1'b1; a = 4'd1; b = 4'd1; cin = 1'b0;
    exp_q.push_back(5'd2);
    for (int i = 0; i < WIDTH; i++) @(negedge clk);
    @(negedge clk);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checks++;
    if (done !== 1'b1 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL b2b_first got done=%b res=%b want 1 %b", done, {cout, sum}, exp);
    end
    a = 4'd6; b = 4'd9; cin = 1'b1;
    exp_q.push_back({1'b0, 4'd6} + {1'b0, 4'd9} + 5'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy cycle %0d got busy=%b done=%b want 1 0", i, busy, done);
      end
      @(negedge clk);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    checks++;
    if (done !== 1'b1 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL b2b_second got done=%b res=%b want 1 %b", done, {cout, sum}, exp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    launch(4'd10, 4'd3, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'b0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got busy=%b done=%b sum=%b cout=%b want 0 0 0000 0", busy, done, sum, cout);
    end
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_done cycle %0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    test_op("midrst_redo", 4'd10, 4'd3, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_op("basic", 4'd3, 4'd5, 1'b0);
    test_op("wrap15p1", 4'd15, 4'd1, 1'b0);
    test_op("wrap31", 4'd15, 4'd15, 1'b1);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
